hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline control block for the 5-stage MIPS datapath; the stall/flush counterpart to the forwarding unit. Forwarding resolves the hazards it can by steering ALU operands. This block resolves the rest: it freezes or bubbles pipeline latches for load-use hazards, instruction/data memory arbitration, taken branches/jumps and halt. It owns a small state machine for data-memory waits and halt, plus a saturating stall-cycle counter.

## Interface
Parameters:
- CNT_W, 32, width of stall_cycles counter

Ports:
- CLK  in  1  clock; one clock domain
- RST  in  1  reset, synchronous, active-high
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmemREN_EX_MEM  in  1  EX/MEM instruction reads data memory
- dmemWEN_EX_MEM  in  1  EX/MEM instruction writes data memory
- opcode_ID_EX  in  opcode_t  opcode in ID/EX
- WEN_ID_EX  in  1  ID/EX instruction writes the register file
- rt_ID_EX  in  regbits_t  load destination in ID/EX
- rs_IF_ID, rt_IF_ID  in  regbits_t  source registers of the instruction in IF/ID
- pc_redirect_EX_MEM  in  1  taken branch or jump resolved in EX/MEM
- halt_MEM_WB  in  1  HALT in MEM/WB
- pc_en  out  1  PC register load enable
- en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB  out  1  latch enables
- flush_IF_ID, flush_ID_EX  out  1  latch loads bubble (all-zero) when its enable is 1
- imemREN  out  1  instruction fetch request
- halt  out  1  sticky processor-halted flag
- stall_cycles  out  CNT_W  stall-cycle count

## Operation
- dreq = dmemREN_EX_MEM | dmemWEN_EX_MEM. lu = (opcode_ID_EX==LW) & WEN_ID_EX & (rt_ID_EX!=0) & (rt_ID_EX==rs_IF_ID | rt_ID_EX==rt_IF_ID).
- imemREN = ~dreq & state==RUN & ~RST. Data has arbitration priority.
- States are RUN, DWAIT and HALTED. Unlisted outputs are 0.
- RUN, priority order:
  - halt_MEM_WB: all enables 0; next HALTED.
  - dreq & ~dhit: all enables 0; next DWAIT.
  - dreq & dhit: use the DWAIT exit outputs; stay RUN.
  - ~ihit: all enables 0.
  - ihit & pc_redirect_EX_MEM: pc_en and all en = 1; flush_IF_ID = flush_ID_EX = 1.
  - ihit & lu: pc_en 0, en_IF_ID 0, en_ID_EX 1 with flush_ID_EX 1, en_EX_MEM and en_MEM_WB 1.
  - ihit otherwise: pc_en and all en = 1.
- DWAIT:
  - ~dhit: all enables 0.
  - dhit (exit): pc_en 0; en_ID_EX, en_EX_MEM, en_MEM_WB = 1.
    - If lu: en_IF_ID 0 and flush_ID_EX 1.
    - Else: en_IF_ID 1 with flush_IF_ID 1, since no fetch completed.
    - Next state RUN.
- HALTED: all enables 0, imemREN 0; exits only on RST.
- halt = 1 exactly while state==HALTED.
- stall_cycles increments by 1 in every cycle with ~RST, state!=HALTED and pc_en==0. It saturates at all-ones and never wraps.
- ihit in DWAIT or HALTED is ignored.

## Timing
- pc_en, en_*, flush_* and imemREN are combinational (Mealy) from the current state and inputs, valid in the same cycle.
- state, halt and stall_cycles are registered; they update on the CLK rising edge.
- Reset (RST=1 at an edge): state RUN, halt 0, stall_cycles 0.
- While RST=1, every combinational output is forced to 0.
- Reset in DWAIT or HALTED returns to RUN at the next edge. A pending dhit in that cycle is discarded.
- Load-use costs exactly 1 bubble. Each data access that misses costs ≥1 DWAIT cycle plus 1 fetch bubble.

## Structure
- opcode_t, regbits_t and LW come from cpu_types_pkg.
- Add hazard_state_t (enum RUN, DWAIT, HALTED; 2 bits) to data_path_muxs_pkg.
- Port bundle goes in hazard_unit_if with modports hu and tb, mirroring forward_unit_if.
- No sub-modules besides the counter, which is a natural sub-module: sat_counter (parameter W; inputs CLK, RST, inc; output count).

## Test plan
- Reset: hold RST 2 cycles with ihit=1 -> all outputs 0, stall_cycles=0. First cycle after: ihit=1 -> pc_en=1, all en=1.
- Load-use: opcode_ID_EX=LW, WEN_ID_EX=1, rt_ID_EX=5, rs_IF_ID=5, ihit=1 -> pc_en=0, en_IF_ID=0, flush_ID_EX=1, stall_cycles +1.
  - Repeat with rt_ID_EX=0 -> no stall.
- Data wait: dmemREN_EX_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> imemREN=0 throughout; 3 cycles of all-zero enables in RUN/DWAIT; exit cycle has flush_IF_ID=1 and state RUN after; stall_cycles +4.
- Redirect: pc_redirect_EX_MEM=1 with ihit=1 -> pc_en=1, flush_IF_ID=flush_ID_EX=1.
  - Same input with ihit=0 -> all enables 0.
- Halt: halt_MEM_WB=1 -> halt=1 next cycle; stays 1 with all outputs 0 and stall_cycles frozen for 10 cycles; RST clears it.
- Saturation: CNT_W=4, ihit=0 for 20 cycles -> stall_cycles reaches 15 and holds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes and register-index width.
// No logic, types only.
// No flow control.
package cpu_types_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [OP_W-1:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDI  = 6'b001000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    HALT  = 6'b111111
  } opcode_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath control-selection types, including the hazard-unit state encoding.
// No logic, types only.
// No flow control.
package data_path_muxs_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Port bundle of the hazard unit.
// hu: the unit's view, tb: the driver's view.
// No flow control; plain wires.
interface hazard_unit_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             RST;
  logic             ihit;
  logic             dhit;
  logic             dmemREN_EX_MEM;
  logic             dmemWEN_EX_MEM;
  opcode_t          opcode_ID_EX;
  logic             WEN_ID_EX;
  regbits_t         rt_ID_EX;
  regbits_t         rs_IF_ID;
  regbits_t         rt_IF_ID;
  logic             pc_redirect_EX_MEM;
  logic             halt_MEM_WB;
  logic             pc_en;
  logic             en_IF_ID;
  logic             en_ID_EX;
  logic             en_EX_MEM;
  logic             en_MEM_WB;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             imemREN;
  logic             halt;
  logic [CNT_W-1:0] stall_cycles;

  modport hu (
    input  RST, ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, opcode_ID_EX,
           WEN_ID_EX, rt_ID_EX, rs_IF_ID, rt_IF_ID, pc_redirect_EX_MEM,
           halt_MEM_WB,
    output pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID,
           flush_ID_EX, imemREN, halt, stall_cycles
  );

  modport tb (
    output RST, ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, opcode_ID_EX,
           WEN_ID_EX, rt_ID_EX, rs_IF_ID, rt_IF_ID, pc_redirect_EX_MEM,
           halt_MEM_WB,
    input  pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID,
           flush_ID_EX, imemREN, halt, stall_cycles
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per cycle while inc is high, sticks at all-ones.
// Latency: count reflects inc one clock later.
// No flow control.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step only while below the ceiling so the value never wraps.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush control: load-use bubbles, I/D memory arbitration, redirect flush, halt.
// Latency: enables/flushes/imemREN are combinational; state, halt, stall count update next edge.
// Backpressure: a pending data access or missing ihit freezes every latch and the PC.
module hazard_unit
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_EX_MEM,
  input  logic             dmemWEN_EX_MEM,
  input  opcode_t          opcode_ID_EX,
  input  logic             WEN_ID_EX,
  input  regbits_t         rt_ID_EX,
  input  regbits_t         rs_IF_ID,
  input  regbits_t         rt_IF_ID,
  input  logic             pc_redirect_EX_MEM,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             imemREN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles
);

  hazard_state_t state_q;
  hazard_state_t state_d;
  logic          halt_q;
  logic          halt_d;
  logic          dreq;
  logic          lu;
  logic          cnt_inc;

  // Data access in MEM owns the single memory port; load-use needs the
  // loaded register to be a real (non-zero) source of the next instruction.
  assign dreq = dmemREN_EX_MEM | dmemWEN_EX_MEM;
  assign lu   = (opcode_ID_EX == LW) & WEN_ID_EX & (rt_ID_EX != '0) &
                ((rt_ID_EX == rs_IF_ID) | (rt_ID_EX == rt_IF_ID));

  // State and halt flag registers; reset always returns to RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Next state: data miss parks in DWAIT, halt is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_MEM_WB) begin
          state_d = HALTED;
        end else if (dreq && !dhit) begin
          state_d = DWAIT;
        end
      end
      DWAIT: begin
        if (dhit) begin
          state_d = RUN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    halt_d = (state_d == HALTED);
  end

  // Latch enables and flushes; a completed data access advances the back of
  // the pipe while IF/ID takes a bubble (no fetch completed) or holds for load-use.
  always_comb begin
    pc_en       = 1'b0;
    en_IF_ID    = 1'b0;
    en_ID_EX    = 1'b0;
    en_EX_MEM   = 1'b0;
    en_MEM_WB   = 1'b0;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    imemREN     = 1'b0;
    if (!RST) begin
      imemREN = !dreq && (state_q == RUN);
      if (((state_q == RUN) && !halt_MEM_WB && dreq && dhit) ||
          ((state_q == DWAIT) && dhit)) begin
        en_ID_EX  = 1'b1;
        en_EX_MEM = 1'b1;
        en_MEM_WB = 1'b1;
        if (lu) begin
          flush_ID_EX = 1'b1;
        end else begin
          en_IF_ID    = 1'b1;
          flush_IF_ID = 1'b1;
        end
      end else if ((state_q == RUN) && !halt_MEM_WB && !dreq && ihit) begin
        en_ID_EX  = 1'b1;
        en_EX_MEM = 1'b1;
        en_MEM_WB = 1'b1;
        if (pc_redirect_EX_MEM) begin
          pc_en       = 1'b1;
          en_IF_ID    = 1'b1;
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end else if (lu) begin
          flush_ID_EX = 1'b1;
        end else begin
          pc_en    = 1'b1;
          en_IF_ID = 1'b1;
        end
      end
    end
  end

  // Every non-halted cycle that fails to advance the PC counts as a stall.
  assign cnt_inc = !RST && (state_q != HALTED) && !pc_en;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (cnt_inc),
    .count (stall_cycles)
  );

  assign halt = halt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: reset, load-use, data waits, redirect, halt, saturation.
// A second instance with a 4-bit counter shares the inputs to exercise saturation.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  // {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, imemREN}
  localparam logic [7:0] O_ZERO  = 8'b0000_0000;
  localparam logic [7:0] O_IDLE  = 8'b0000_0001;
  localparam logic [7:0] O_RUN   = 8'b1111_1001;
  localparam logic [7:0] O_LU    = 8'b0011_1011;
  localparam logic [7:0] O_DX    = 8'b0111_1100;
  localparam logic [7:0] O_DXLU  = 8'b0011_1010;
  localparam logic [7:0] O_REDIR = 8'b1111_1111;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_unit_if #(.CNT_W(32)) huif ();

  logic       s_pc_en, s_en_IF_ID, s_en_ID_EX, s_en_EX_MEM, s_en_MEM_WB;
  logic       s_flush_IF_ID, s_flush_ID_EX, s_imemREN, s_halt;
  logic [3:0] s_stall;

  hazard_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(huif.RST), .ihit(huif.ihit), .dhit(huif.dhit),
    .dmemREN_EX_MEM(huif.dmemREN_EX_MEM), .dmemWEN_EX_MEM(huif.dmemWEN_EX_MEM),
    .opcode_ID_EX(huif.opcode_ID_EX), .WEN_ID_EX(huif.WEN_ID_EX),
    .rt_ID_EX(huif.rt_ID_EX), .rs_IF_ID(huif.rs_IF_ID), .rt_IF_ID(huif.rt_IF_ID),
    .pc_redirect_EX_MEM(huif.pc_redirect_EX_MEM), .halt_MEM_WB(huif.halt_MEM_WB),
    .pc_en(huif.pc_en), .en_IF_ID(huif.en_IF_ID), .en_ID_EX(huif.en_ID_EX),
    .en_EX_MEM(huif.en_EX_MEM), .en_MEM_WB(huif.en_MEM_WB),
    .flush_IF_ID(huif.flush_IF_ID), .flush_ID_EX(huif.flush_ID_EX),
    .imemREN(huif.imemREN), .halt(huif.halt), .stall_cycles(huif.stall_cycles)
  );

  hazard_unit #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(huif.RST), .ihit(huif.ihit), .dhit(huif.dhit),
    .dmemREN_EX_MEM(huif.dmemREN_EX_MEM), .dmemWEN_EX_MEM(huif.dmemWEN_EX_MEM),
    .opcode_ID_EX(huif.opcode_ID_EX), .WEN_ID_EX(huif.WEN_ID_EX),
    .rt_ID_EX(huif.rt_ID_EX), .rs_IF_ID(huif.rs_IF_ID), .rt_IF_ID(huif.rt_IF_ID),
    .pc_redirect_EX_MEM(huif.pc_redirect_EX_MEM), .halt_MEM_WB(huif.halt_MEM_WB),
    .pc_en(s_pc_en), .en_IF_ID(s_en_IF_ID), .en_ID_EX(s_en_ID_EX),
    .en_EX_MEM(s_en_EX_MEM), .en_MEM_WB(s_en_MEM_WB),
    .flush_IF_ID(s_flush_IF_ID), .flush_ID_EX(s_flush_ID_EX),
    .imemREN(s_imemREN), .halt(s_halt), .stall_cycles(s_stall)
  );

  logic [7:0] outs;
  assign outs = {huif.pc_en, huif.en_IF_ID, huif.en_ID_EX, huif.en_EX_MEM,
                 huif.en_MEM_WB, huif.flush_IF_ID, huif.flush_ID_EX, huif.imemREN};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: check combinational outputs mid-cycle, then the stall count after the edge.
  task automatic cyc(input string tag, input logic [7:0] exp_outs, input bit stalls);
    @(negedge CLK);
    check(tag, {24'b0, outs}, {24'b0, exp_outs});
    if (stalls) exp_stall++;
    @(posedge CLK);
    #1;
    check({tag, "_cnt"}, huif.stall_cycles, exp_stall);
  endtask

  task automatic set_lu(input bit on);
    huif.opcode_ID_EX = on ? LW : RTYPE;
    huif.WEN_ID_EX    = on;
    huif.rt_ID_EX     = on ? 5'd5 : 5'd0;
    huif.rs_IF_ID     = on ? 5'd5 : 5'd0;
    huif.rt_IF_ID     = 5'd0;
  endtask

  initial begin
    huif.RST = 1'b1; huif.ihit = 1'b1; huif.dhit = 1'b0;
    huif.dmemREN_EX_MEM = 1'b0; huif.dmemWEN_EX_MEM = 1'b0;
    huif.pc_redirect_EX_MEM = 1'b0; huif.halt_MEM_WB = 1'b0;
    set_lu(1'b0);
    exp_stall = 0;

    // Reset held two cycles with ihit high.
    cyc("rst0", O_ZERO, 0);
    cyc("rst1", O_ZERO, 0);
    check("rst_halt", {31'b0, huif.halt}, 32'd0);
    huif.RST = 1'b0;
    cyc("run0", O_RUN, 0);

    // Saturation: 20 fetch misses; the 4-bit copy tops out at 15.
    huif.ihit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc("sat", O_IDLE, 1);
      if (i == 13) check("sat4_14", {28'b0, s_stall}, 32'd14);
      if (i == 14) check("sat4_15", {28'b0, s_stall}, 32'd15);
    end
    check("sat4_hold", {28'b0, s_stall}, 32'd15);
    huif.ihit = 1'b1;

    // Load-use via rs, rt=0 exemption, via rt, WEN off, non-load opcode.
    set_lu(1'b1);
    cyc("lu_rs", O_LU, 1);
    huif.rt_ID_EX = 5'd0;
    cyc("lu_r0", O_RUN, 0);
    huif.rt_ID_EX = 5'd7; huif.rt_IF_ID = 5'd7;
    cyc("lu_rt", O_LU, 1);
    huif.WEN_ID_EX = 1'b0;
    cyc("lu_nowen", O_RUN, 0);
    huif.WEN_ID_EX = 1'b1; huif.opcode_ID_EX = RTYPE;
    cyc("lu_notlw", O_RUN, 0);
    set_lu(1'b0);

    // Data miss: three wait cycles then the exit cycle; four stalls total.
    huif.dmemREN_EX_MEM = 1'b1;
    cyc("dwait0", O_ZERO, 1);
    cyc("dwait1", O_ZERO, 1);
    cyc("dwait2", O_ZERO, 1);
    huif.dhit = 1'b1;
    cyc("dexit", O_DX, 1);
    huif.dmemREN_EX_MEM = 1'b0; huif.dhit = 1'b0;
    cyc("dafter", O_RUN, 0);

    // Data hit straight from RUN.
    huif.dmemWEN_EX_MEM = 1'b1; huif.dhit = 1'b1;
    cyc("dhit_run", O_DX, 1);
    huif.dmemWEN_EX_MEM = 1'b0; huif.dhit = 1'b0;
    cyc("dhit_after", O_RUN, 0);

    // Wait exit while a load-use is pending.
    huif.dmemREN_EX_MEM = 1'b1;
    cyc("dwait_lu", O_ZERO, 1);
    set_lu(1'b1); huif.dhit = 1'b1;
    cyc("dexit_lu", O_DXLU, 1);
    huif.dmemREN_EX_MEM = 1'b0; huif.dhit = 1'b0;
    cyc("lu_after_dx", O_LU, 1);
    set_lu(1'b0);
    cyc("lu_clear", O_RUN, 0);

    // Redirect: with fetch, without fetch, and over a load-use.
    huif.pc_redirect_EX_MEM = 1'b1;
    cyc("redir", O_REDIR, 0);
    huif.ihit = 1'b0;
    cyc("redir_nohit", O_IDLE, 1);
    huif.ihit = 1'b1; set_lu(1'b1);
    cyc("redir_lu", O_REDIR, 0);
    huif.pc_redirect_EX_MEM = 1'b0; set_lu(1'b0);

    // Reset while in DWAIT with a pending dhit lands in RUN.
    huif.dmemREN_EX_MEM = 1'b1;
    cyc("rst_dw_pre", O_ZERO, 1);
    huif.RST = 1'b1; huif.dhit = 1'b1; exp_stall = 0;
    cyc("rst_dw", O_ZERO, 0);
    huif.RST = 1'b0; huif.dhit = 1'b0; huif.dmemREN_EX_MEM = 1'b0;
    cyc("rst_dw_after", O_RUN, 0);

    // Halt: request cycle stalls, then frozen for ten cycles, reset clears.
    huif.ihit = 1'b0;
    cyc("pre_halt", O_IDLE, 1);
    huif.ihit = 1'b1; huif.halt_MEM_WB = 1'b1;
    cyc("halt_req", O_IDLE, 1);
    check("halt_set", {31'b0, huif.halt}, 32'd1);
    huif.halt_MEM_WB = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc("halted", O_ZERO, 0);
      check("halted_flag", {31'b0, huif.halt}, 32'd1);
    end
    huif.RST = 1'b1; exp_stall = 0;
    cyc("halt_rst", O_ZERO, 0);
    check("halt_clr", {31'b0, huif.halt}, 32'd0);
    huif.RST = 1'b0;
    cyc("post_halt", O_RUN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
